chunked_lookahead_subtractor: RTL and testbench



---
 rtl/chunked_lookahead_subtractor.sv | 128 ++++++++++++
 tb/tb_chunked_lookahead_subtractor.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/chunked_lookahead_subtractor.sv
// rtl/chunked_lookahead_subtractor.sv - multi-cycle subtractor, CHUNK bits per clock
// Borrow lookahead within a chunk, registered borrow between chunks.
module chunked_lookahead_subtractor #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bw_i,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bw_o,
    output logic             ovf
);
    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, d_q, d_d;
    logic             bw_q, bw_d, bwo_q, bwo_d, ovf_q, ovf_d;
    logic [KW-1:0]    k_q, k_d;

    logic [CHUNK-1:0] ca, cb, cg, cp, cdiff;
    logic [CHUNK:0]   cbr;
    logic             term;

    // Each borrow is a flat OR of generate terms gated by the propagates above them.
    always_comb begin
        ca   = a_q[int'(k_q)*CHUNK +: CHUNK];
        cb   = b_q[int'(k_q)*CHUNK +: CHUNK];
        cg   = ~ca & cb;
        cp   = ~(ca ^ cb);
        term = 1'b0;
        cbr  = '0;
        cbr[0] = bw_q;
        for (int j = 0; j < CHUNK; j++) begin
            term = bw_q;
            for (int m = 0; m <= j; m++) begin
                term = term & cp[m];
            end
            cbr[j+1] = term;
            for (int m = 0; m <= j; m++) begin
                term = cg[m];
                for (int n = m + 1; n <= j; n++) begin
                    term = term & cp[n];
                end
                cbr[j+1] = cbr[j+1] | term;
            end
        end
        cdiff = ca ^ cb ^ cbr[CHUNK-1:0];
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        bw_d    = bw_q;
        k_d     = k_q;
        d_d     = d_q;
        bwo_d   = bwo_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start_i) begin
                    a_d     = A;
                    b_d     = B;
                    bw_d    = Bw_i;
                    k_d     = '0;
                    acc_d   = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                acc_d[int'(k_q)*CHUNK +: CHUNK] = cdiff;
                bw_d = cbr[CHUNK];
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    d_d     = acc_d;
                    bwo_d   = cbr[CHUNK];
                    ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) & (acc_d[WIDTH-1] != a_q[WIDTH-1]);
                    state_d = S_DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            bw_q    <= 1'b0;
            k_q     <= '0;
            d_q     <= '0;
            bwo_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            bw_q    <= bw_d;
            k_q     <= k_d;
            d_q     <= d_d;
            bwo_q   <= bwo_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == S_BUSY);
    assign done = (state_q == S_DONE);
    assign D    = d_q;
    assign Bw_o = bwo_q;
    assign ovf  = ovf_q;
endmodule

// File: tb/tb_chunked_lookahead_subtractor.sv
// tb/tb_chunked_lookahead_subtractor.sv - scoreboard bench over CHUNK = 1, 2, 4, 8 at WIDTH = 8
module tb_chunked_lookahead_subtractor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       start [4];
    logic [7:0] a     [4];
    logic [7:0] b     [4];
    logic       bwi   [4];
    logic       busy  [4];
    logic       done  [4];
    logic [7:0] d     [4];
    logic       bwo   [4];
    logic       ovf   [4];

    typedef struct {
        logic [7:0] d;
        logic       bo;
        logic       ov;
        int         at;
    } exp_t;

    exp_t sbq [4][$];
    int   n_pass = 0;
    int   n_total = 0;
    int   sweep_done = 0;
    logic sweep_go = 1'b0;

    function automatic void chk(input string name, input int gi, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s chunk=%0d actual=%0h required=%0h", name, 1 << gi, act, req);
    endfunction

    // Reference: plain wide subtraction plus signed-range test.
    function automatic exp_t model(input logic [7:0] av, input logic [7:0] bv, input logic bw, input int at);
        exp_t       e;
        logic [8:0] full;
        int         s;
        full = {1'b0, av} - {1'b0, bv} - {8'd0, bw};
        s    = int'($signed(av)) - int'($signed(bv)) - int'(bw);
        e.d  = full[7:0];
        e.bo = full[8];
        e.ov = (s < -128) || (s > 127);
        e.at = at;
        return e;
    endfunction

    task automatic drive(input int gi, input logic st, input logic [7:0] av, input logic [7:0] bv, input logic bw);
        start[gi] = st;
        a[gi]     = av;
        b[gi]     = bv;
        bwi[gi]   = bw;
    endtask

    task automatic wait_idle(input int gi);
        int k = 0;
        while (busy[gi] && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) chk("idle_timeout", gi, 32'd1, 32'd0);
    endtask

    task automatic run_op(input int gi, input logic [7:0] av, input logic [7:0] bv, input logic bw,
                          input logic [7:0] ed, input logic ebo, input logic eov);
        exp_t e;
        wait_idle(gi);
        e.d = ed; e.bo = ebo; e.ov = eov;
        e.at = cyc + 1 + (8 >> gi);
        sbq[gi].push_back(e);
        drive(gi, 1'b1, av, bv, bw);
        @(negedge clk);
        drive(gi, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
    endtask

    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        exp_t me;

        chunked_lookahead_subtractor #(.WIDTH(8), .CHUNK(1 << gi)) dut (
            .clk     (clk),
            .rst     (rst),
            .start_i (start[gi]),
            .A       (a[gi]),
            .B       (b[gi]),
            .Bw_i    (bwi[gi]),
            .busy    (busy[gi]),
            .done    (done[gi]),
            .D       (d[gi]),
            .Bw_o    (bwo[gi]),
            .ovf     (ovf[gi])
        );

        always @(negedge clk) begin
            if (!rst && done[gi]) begin
                if (sbq[gi].size() == 0) begin
                    chk("unexpected_done", gi, 32'd1, 32'd0);
                end else begin
                    me = sbq[gi].pop_front();
                    chk("D", gi, 32'(d[gi]), 32'(me.d));
                    chk("Bw_o", gi, 32'(bwo[gi]), 32'(me.bo));
                    chk("ovf", gi, 32'(ovf[gi]), 32'(me.ov));
                    chk("done_cycle", gi, cyc, me.at);
                end
            end
        end

        initial begin
            exp_t       e;
            logic [7:0] ra, rb;
            logic       rbw;
            wait (sweep_go);
            @(negedge clk);
            for (int n = 0; n < 40; n++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                ra  = 8'($urandom);
                rb  = 8'($urandom);
                rbw = 1'($urandom);
                e   = model(ra, rb, rbw, 0);
                run_op(gi, ra, rb, rbw, e.d, e.bo, e.ov);
            end
            sweep_done++;
        end
    end

    initial begin
        int x;
        int t;
        for (int i = 0; i < 4; i++) drive(i, 1'b0, 8'h00, 8'h00, 1'b0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++)
            chk("reset_outputs", i, {20'd0, busy[i], done[i], d[i], bwo[i], ovf[i]}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(2, 8'h50, 8'h30, 1'b0, 8'h20, 1'b0, 1'b0);
        run_op(2, 8'h30, 8'h50, 1'b0, 8'hE0, 1'b1, 1'b0);
        run_op(2, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
        run_op(2, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        run_op(2, 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);

        // start held high: second operands presented during BUSY are taken in the DONE cycle
        wait_idle(2);
        x = cyc;
        sbq[2].push_back('{d: 8'hDE, bo: 1'b1, ov: 1'b0, at: x + 3});
        sbq[2].push_back('{d: 8'h7A, bo: 1'b0, ov: 1'b1, at: x + 6});
        drive(2, 1'b1, 8'h12, 8'h34, 1'b0);
        @(negedge clk);
        drive(2, 1'b1, 8'h9C, 8'h21, 1'b1);
        repeat (3) @(negedge clk);
        chk("back_to_back_busy", 2, 32'(busy[2]), 32'd1);
        drive(2, 1'b0, 8'h00, 8'h00, 1'b0);
        repeat (8) @(negedge clk);
        chk("held_D", 2, 32'(d[2]), 32'h7A);
        chk("held_ovf", 2, 32'(ovf[2]), 32'd1);

        // reset after chunk 0 of an in-flight operation
        wait_idle(2);
        drive(2, 1'b1, 8'h55, 8'h11, 1'b0);
        @(negedge clk);
        drive(2, 1'b0, 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midop_reset", 2, {20'd0, busy[2], done[2], d[2], bwo[2], ovf[2]}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("no_done_after_reset", 2, 32'(sbq[2].size()), 32'd0);
        run_op(2, 8'h55, 8'h11, 1'b0, 8'h44, 1'b0, 1'b0);

        sweep_go = 1'b1;
        t = 0;
        while (sweep_done < 4 && t < 20000) begin
            @(negedge clk);
            t++;
        end
        chk("sweep_finished", 0, 32'(sweep_done), 32'd4);
        repeat (20) @(negedge clk);
        for (int i = 0; i < 4; i++) chk("queue_drained", i, 32'(sbq[i].size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
